// File: rtl/prefix_adder.sv
// rtl/prefix_adder.sv - registered Kogge-Stone adder with carry-in and carry-out
module prefix_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] term0,
  input  logic [WIDTH-1:0] term1,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Node j of the network stands for bit position j-1; node 0 carries cin as a generate.
  localparam int NODES  = WIDTH + 1;
  localparam int LEVELS = (NODES > 1) ? $clog2(NODES) : 1;

  logic [WIDTH-1:0] p;
  logic [NODES-1:0] g_cur, p_cur, g_nxt, p_nxt;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  assign p = term0 ^ term1;

  always_comb begin
    g_cur = {term0 & term1, cin};
    p_cur = {p, 1'b0};
    g_nxt = '0;
    p_nxt = '0;
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < NODES; j++) begin
        if (j >= (1 << k)) begin
          g_nxt[j] = g_cur[j] | (p_cur[j] & g_cur[j - (1 << k)]);
          p_nxt[j] = p_cur[j] & p_cur[j - (1 << k)];
        end else begin
          g_nxt[j] = g_cur[j];
          p_nxt[j] = p_cur[j];
        end
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    // After the last level g_cur[j] is the group generate from position -1 up to j-1.
    sum_next  = p ^ g_cur[WIDTH-1:0];
    cout_next = g_cur[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= cout_next;
    end
  end

endmodule

// File: tb/tb_prefix_adder.sv
// tb/tb_prefix_adder.sv - directed and sweep checks for prefix_adder at several widths
module tb_prefix_adder;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  a8, b8, s8;
  logic        c8, co8;
  logic [0:0]  a1, b1, s1;
  logic        c1, co1;
  logic [4:0]  a5, b5, s5;
  logic        c5, co5;
  logic [15:0] a16, b16, s16;
  logic        c16, co16;
  logic [31:0] a32, b32, s32;
  logic        c32, co32;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prefix_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .term0(a8),  .term1(b8),  .cin(c8),  .sum(s8),  .cout(co8));
  prefix_adder #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .term0(a1),  .term1(b1),  .cin(c1),  .sum(s1),  .cout(co1));
  prefix_adder #(.WIDTH(5))  u5  (.clk(clk), .rst(rst), .term0(a5),  .term1(b5),  .cin(c5),  .sum(s5),  .cout(co5));
  prefix_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .term0(a16), .term1(b16), .cin(c16), .sum(s16), .cout(co16));
  prefix_adder #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .term0(a32), .term1(b32), .cin(c32), .sum(s32), .cout(co32));

  task automatic chk8(input string tag, input logic [8:0] exp);
    n_assert++;
    assert ({co8, s8} === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, {co8, s8}, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  va [9];
  logic [7:0]  vb [9];
  logic        vc [9];
  logic [8:0]  ve [9];
  logic [8:0]  e8;
  logic [1:0]  e1;
  logic [5:0]  e5;
  logic [16:0] e16;
  logic [32:0] e32;
  logic [10:0] idx5;
  logic [2:0]  idx1;

  initial begin
    va = '{8'h00, 8'hF0, 8'hF0, 8'hB4, 8'h00, 8'h90, 8'hFF, 8'h80, 8'h7F};
    vb = '{8'h0F, 8'h0F, 8'h0F, 8'h49, 8'hEF, 8'h49, 8'h00, 8'h80, 8'h00};
    vc = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    ve = '{9'h00F, 9'h100, 9'h0FF, 9'h0FD, 9'h0EF, 9'h0D9, 9'h100, 9'h100, 9'h080};

    rst = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    a1 = 1'b1;  b1 = 1'b1;  c1 = 1'b1;
    a5 = 5'h1F; b5 = 5'h1F; c5 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; c32 = 1'b1;

    cycle();
    chk8("reset_cycle1", 9'h000);
    cycle();
    chk8("reset_cycle2", 9'h000);
    n_assert++;
    assert ({co1, s1, co5, s5, co16, s16, co32, s32} === '0) else begin
      n_fail++;
      $error("FAIL reset_sweep: observed nonzero output on w1/w5/w16/w32");
    end

    rst = 1'b0;
    cycle();
    chk8("reset_release", 9'h1FF);

    for (int i = 0; i < 9; i++) begin
      a8 = va[i]; b8 = vb[i]; c8 = vc[i];
      cycle();
      chk8($sformatf("directed_%0d", i), ve[i]);
    end

    for (int i = 0; i < 256; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      e8 = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
      cycle();
      chk8($sformatf("throughput_%0d", i), e8);
    end

    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    cycle();
    chk8("mid_before", 9'h046);
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; rst = 1'b1;
    cycle();
    chk8("mid_reset", 9'h000);
    a8 = 8'h55; b8 = 8'hAA; c8 = 1'b1; rst = 1'b0;
    cycle();
    chk8("mid_after", 9'h100);

    for (int n = 0; n < 10000; n++) begin
      idx5 = 11'(n);
      idx1 = 3'(n);
      a5 = idx5[4:0]; b5 = idx5[9:5]; c5 = idx5[10];
      a1 = idx1[0:0]; b1 = idx1[1:1]; c1 = idx1[2];
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
      e1  = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
      e5  = {1'b0, a5} + {1'b0, b5} + {5'h00, c5};
      e16 = {1'b0, a16} + {1'b0, b16} + {16'h0000, c16};
      e32 = {1'b0, a32} + {1'b0, b32} + {32'h0, c32};
      cycle();
      n_assert++;
      assert ({co1, s1} === e1) else begin
        n_fail++;
        $error("FAIL sweep_w1_%0d: observed %h expected %h", n, {co1, s1}, e1);
      end
      n_assert++;
      assert ({co5, s5} === e5) else begin
        n_fail++;
        $error("FAIL sweep_w5_%0d: observed %h expected %h", n, {co5, s5}, e5);
      end
      n_assert++;
      assert ({co16, s16} === e16) else begin
        n_fail++;
        $error("FAIL sweep_w16_%0d: observed %h expected %h", n, {co16, s16}, e16);
      end
      n_assert++;
      assert ({co32, s32} === e32) else begin
        n_fail++;
        $error("FAIL sweep_w32_%0d: observed %h expected %h", n, {co32, s32}, e32);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
